// File: rtl/serdes_pkg.sv
// Shared serdes definitions: line state encoding and idle level.
// Used by the serializer now and the deserializer later.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer in front of the shift register.
// ready is a pure register decode, so it never depends on wr_valid.
module piso_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic             full_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;

    // A drain only happens while full, an accept only while empty.
    always_comb begin
        accept = wr_valid_i && !full_q;
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    // Buffer flag and word storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o  = full_q;
    assign ready_o = !full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// Words stream gaplessly while the buffer is refilled in time.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic        IDLE_BIT  = IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             out_q, out_d;
    logic             ov_q, ov_d;
    logic             fs_q, fs_d;
    logic             load;
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_valid_i(data_valid),
        .wr_data_i (data),
        .rd_i      (load),
        .full_o    (buf_full),
        .ready_o   (data_ready),
        .data_o    (buf_data)
    );

    // The first bit leaves on the load edge, so the shift
    // register only ever holds the bits still to be sent.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Next-state logic: shift, gapless reload, or return to idle.
    always_comb begin
        load    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        out_d   = out_q;
        ov_d    = ov_q;
        fs_d    = 1'b0;
        if (enb) begin
            unique case (state_q)
                IDLE: begin
                    load = buf_full;
                end
                SHIFT: begin
                    if (cnt_q < LAST) begin
                        out_d  = head(sreg_q);
                        sreg_d = adv(sreg_q);
                        cnt_d  = cnt_q + CW'(1);
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        out_d   = IDLE_BIT;
                        ov_d    = 1'b0;
                    end
                end
            endcase
            if (load) begin
                state_d = SHIFT;
                out_d   = head(buf_data);
                sreg_d  = adv(buf_data);
                ov_d    = 1'b1;
                fs_d    = 1'b1;
                cnt_d   = CW'(1);
            end
        end
    end

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            out_q   <= IDLE_BIT;
            ov_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            fs_q    <= fs_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = ov_q;
    assign frame_start = fs_q;
    assign busy        = (state_q == SHIFT) || buf_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances
// share stimulus; a scoreboard tracks each serial stream.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       data_valid;
    logic [7:0] data;

    logic rdy_m, out_m, ov_m, fs_m, busy_m;
    logic rdy_l, out_l, ov_l, fs_l, busy_l;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [1:0] e_m, e_l;
    logic       last_m, last_l;
    logic       en_s;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .enb(enb), .data(data),
        .data_valid(data_valid), .data_ready(rdy_m), .out(out_m),
        .out_valid(ov_m), .frame_start(fs_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .enb(enb), .data(data),
        .data_valid(data_valid), .data_ready(rdy_l), .out(out_l),
        .out_valid(ov_l), .frame_start(fs_l), .busy(busy_l)
    );

    // Expected {frame_start, bit} per serial slot, in send order.
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q_m.push_back({i == 0, w[7-i]});
            q_l.push_back({i == 0, w[i]});
        end
    endtask

    // Called just after a negedge; returns at the negedge after accept.
    task automatic offer(input logic [7:0] w);
        bit ok = 1'b0;
        data = w;
        data_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rdy_m) begin
                @(posedge clk);
                push_word(w);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL offer_%h: data_ready=%b never reached 1", w, rdy_m);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy_m && !busy_l && !ov_m && !ov_l) done = 1'b1;
        end
        n_vec++;
        if (!done || q_m.size() != 0 || q_l.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: idle=%b left m=%0d l=%0d required idle=1 left 0/0",
                     tag, done, q_m.size(), q_l.size());
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({out_m, ov_m, fs_m, rdy_m, busy_m} !== 5'b00010) begin
            n_err++;
            $display("FAIL reset_m: out/ov/fs/rdy/busy=%b required 00010",
                     {out_m, ov_m, fs_m, rdy_m, busy_m});
        end
        n_vec++;
        if ({out_l, ov_l, fs_l, rdy_l, busy_l} !== 5'b00010) begin
            n_err++;
            $display("FAIL reset_l: out/ov/fs/rdy/busy=%b required 00010",
                     {out_l, ov_l, fs_l, rdy_l, busy_l});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_single();
        offer(8'h88);
        n_vec++;
        if (ov_m !== 1'b0) begin
            n_err++;
            $display("FAIL msb_latency: out_valid=%b required 0 before load", ov_m);
        end
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            n_vec++;
            if (ov_m !== (i <= 8) || fs_m !== (i == 1)) begin
                n_err++;
                $display("FAIL msb_slot%0d: ov/fs=%b%b required %b%b",
                         i, ov_m, fs_m, i <= 8, i == 1);
            end
        end
        n_vec++;
        if (out_m !== 1'b0) begin
            n_err++;
            $display("FAIL msb_idle_out: out=%b required 0", out_m);
        end
        wait_idle("msb");
    endtask

    task automatic test_lsb_single();
        offer(8'hA1);
        n_vec++;
        if (rdy_l !== 1'b0) begin
            n_err++;
            $display("FAIL lsb_ready_low: data_ready=%b required 0", rdy_l);
        end
        @(negedge clk);
        n_vec++;
        if ({rdy_l, ov_l, out_l, fs_l} !== 4'b1111) begin
            n_err++;
            $display("FAIL lsb_first_bit: rdy/ov/out/fs=%b required 1111",
                     {rdy_l, ov_l, out_l, fs_l});
        end
        wait_idle("lsb");
    endtask

    task automatic test_back_to_back();
        offer(8'hF0);
        offer(8'h0F);
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (ov_m !== 1'b1 || ov_l !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_gap%0d: out_valid m/l=%b%b required 11",
                         i + 2, ov_m, ov_l);
            end
            @(negedge clk);
        end
        n_vec++;
        if (ov_m !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: out_valid=%b required 0", ov_m);
        end
        wait_idle("b2b");
    endtask

    task automatic test_enb_stall();
        offer(8'hC3);
        repeat (3) @(negedge clk);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_m, ov_m, out_l, ov_l} !== 4'b0101) begin
                n_err++;
                $display("FAIL stall_hold%0d: out/ov m,l=%b required 0101",
                         i, {out_m, ov_m, out_l, ov_l});
            end
        end
        enb = 1'b1;
        wait_idle("stall");
    endtask

    task automatic test_backpressure();
        offer(8'h3C);
        offer(8'hE7);
        data = 8'h55;
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rdy_m !== 1'b0 || rdy_l !== 1'b0 || busy_m !== 1'b1) begin
                n_err++;
                $display("FAIL bp_ready%0d: rdy m/l=%b%b busy=%b required 001",
                         i, rdy_m, rdy_l, busy_m);
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        wait_idle("bp");
    endtask

    task automatic test_reset_mid_word();
        offer(8'hFF);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({out_m, ov_m, fs_m, rdy_m, busy_m} !== 5'b00010) begin
            n_err++;
            $display("FAIL async_reset_m: out/ov/fs/rdy/busy=%b required 00010",
                     {out_m, ov_m, fs_m, rdy_m, busy_m});
        end
        n_vec++;
        if ({out_l, ov_l, rdy_l, busy_l} !== 4'b0010) begin
            n_err++;
            $display("FAIL async_reset_l: out/ov/rdy/busy=%b required 0010",
                     {out_l, ov_l, rdy_l, busy_l});
        end
        q_m.delete();
        q_l.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        offer(8'h81);
        wait_idle("post_reset");
    endtask

    initial begin
        reset = 1'b1;
        enb = 1'b1;
        data_valid = 1'b0;
        data = '0;
        last_m = 1'b0;
        last_l = 1'b0;
        en_s = 1'b0;
        fork
            forever begin
                @(posedge clk);
                en_s = enb;
                @(negedge clk);
                if (!reset) begin
                    n_vec++;
                    if (en_s && ov_m) begin
                        if (q_m.size() == 0) begin
                            n_err++;
                            $display("FAIL msb_extra: out=%b with nothing expected", out_m);
                        end else begin
                            e_m = q_m.pop_front();
                            last_m = e_m[0];
                            if ({fs_m, out_m} !== e_m) begin
                                n_err++;
                                $display("FAIL msb_bit: fs/out=%b%b required %b",
                                         fs_m, out_m, e_m);
                            end
                        end
                    end else if (ov_m) begin
                        if (out_m !== last_m || fs_m !== 1'b0) begin
                            n_err++;
                            $display("FAIL msb_hold: fs/out=%b%b required 0%b",
                                     fs_m, out_m, last_m);
                        end
                    end else if (out_m !== 1'b0 || fs_m !== 1'b0) begin
                        n_err++;
                        $display("FAIL msb_idle: fs/out=%b%b required 00", fs_m, out_m);
                    end
                    n_vec++;
                    if (en_s && ov_l) begin
                        if (q_l.size() == 0) begin
                            n_err++;
                            $display("FAIL lsb_extra: out=%b with nothing expected", out_l);
                        end else begin
                            e_l = q_l.pop_front();
                            last_l = e_l[0];
                            if ({fs_l, out_l} !== e_l) begin
                                n_err++;
                                $display("FAIL lsb_bit: fs/out=%b%b required %b",
                                         fs_l, out_l, e_l);
                            end
                        end
                    end else if (ov_l) begin
                        if (out_l !== last_l || fs_l !== 1'b0) begin
                            n_err++;
                            $display("FAIL lsb_hold: fs/out=%b%b required 0%b",
                                     fs_l, out_l, last_l);
                        end
                    end else if (out_l !== 1'b0 || fs_l !== 1'b0) begin
                        n_err++;
                        $display("FAIL lsb_idle: fs/out=%b%b required 00", fs_l, out_l);
                    end
                end
            end
        join_none
        test_reset();
        test_msb_single();
        test_lsb_single();
        test_back_to_back();
        test_enb_stall();
        test_backpressure();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
